// File: rtl/calc_operand_engine_if.sv
// Key-event inputs and display outputs of the calculator operand engine.
// The keypad side drives the master modport; the engine uses the slave modport.
interface calc_operand_engine_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       num;
    logic             numPressed;
    logic [2:0]       opt;
    logic             optPressed;
    logic             submit;
    logic [WIDTH-1:0] display;
    logic             negative;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output num, numPressed, opt, optPressed, submit,
        input  display, negative, busy, done, error
    );

    modport slave (
        input  num, numPressed, opt, optPressed, submit,
        output display, negative, busy, done, error
    );
endinterface

// File: rtl/calc_operand_engine.sv
// Keypad-driven decimal calculator core: assembles two operands, runs + - * in
// a single cycle and / % through a restoring divider, one quotient bit per cycle.
module calc_operand_engine #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input logic                  clk,
    input logic                  reset,
    calc_operand_engine_if.slave bus
);
    localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam int ITER_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;
    localparam logic [2:0] OP_MOD = 3'd5;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        DIVIDE,
        RESULT,
        ERROR
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [WIDTH-1:0]    quo;
    logic [WIDTH-1:0]    rem;
    logic [WIDTH-1:0]    display_r;
    logic [2:0]          op;
    logic [CNT_W-1:0]    cnt;
    logic [ITER_W-1:0]   iter;
    logic                negative_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;
    logic                num_p0;
    logic                opt_p0;
    logic                sub_p0;

    logic                sub_ev;
    logic                opt_ev;
    logic                dig_ev;
    logic                opt_ok;
    logic                cnt_room;
    logic [WIDTH-1:0]    digit_w;
    logic [WIDTH-1:0]    a_next;
    logic [WIDTH-1:0]    b_next;
    logic [WIDTH:0]      sum_w;
    logic [2*WIDTH-1:0]  prod_w;

    function automatic logic [WIDTH-1:0] append_digit(input logic [WIDTH-1:0] v,
                                                      input logic [WIDTH-1:0] d);
        return (v << 3) + (v << 1) + d;
    endfunction

    // One restoring step: shift the next dividend bit into the partial remainder,
    // subtract the divisor and keep the result only when it did not borrow.
    // Because the partial remainder stays below the divisor, the borrow bit alone
    // decides the quotient bit. Returns {remainder, quotient}.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sh;
        logic [WIDTH:0] t;
        sh = {r, q[WIDTH-1]};
        t  = sh - {1'b0, d};
        if (t[WIDTH])
            return {sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
        return {t[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    endfunction

    assign sub_ev   = bus.submit & ~sub_p0 & ~busy_r;
    assign opt_ev   = bus.optPressed & ~opt_p0 & ~busy_r & ~sub_ev;
    assign dig_ev   = bus.numPressed & ~num_p0 & ~busy_r & ~sub_ev & ~opt_ev
                      & (bus.num <= 4'd9);
    assign opt_ok   = (bus.opt >= OP_ADD) && (bus.opt <= OP_MOD);
    assign cnt_room = (cnt < CNT_W'(MAX_DIGITS));
    assign digit_w  = {{(WIDTH-4){1'b0}}, bus.num};
    assign a_next   = append_digit(a, digit_w);
    assign b_next   = append_digit(b, digit_w);
    assign sum_w    = {1'b0, a} + {1'b0, b};
    assign prod_w   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign bus.display  = display_r;
    assign bus.negative = negative_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.error    = error_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ENTER_A;
            a          <= '0;
            b          <= '0;
            quo        <= '0;
            rem        <= '0;
            display_r  <= '0;
            op         <= '0;
            cnt        <= '0;
            iter       <= '0;
            negative_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            num_p0     <= 1'b0;
            opt_p0     <= 1'b0;
            sub_p0     <= 1'b0;
        end else begin
            num_p0 <= bus.numPressed;
            opt_p0 <= bus.optPressed;
            sub_p0 <= bus.submit;
            done_r <= 1'b0;

            unique case (state)
                ENTER_A: begin
                    if (sub_ev) begin
                        done_r    <= 1'b1;
                        display_r <= a;
                    end else if (opt_ev && opt_ok) begin
                        op    <= bus.opt;
                        b     <= '0;
                        cnt   <= '0;
                        state <= ENTER_B;
                    end else if (dig_ev && cnt_room) begin
                        a         <= a_next;
                        cnt       <= cnt + CNT_W'(1);
                        display_r <= a_next;
                    end
                end

                ENTER_B: begin
                    if (sub_ev) begin
                        if (op == OP_DIV || op == OP_MOD) begin
                            state  <= DIVIDE;
                            busy_r <= 1'b1;
                            quo    <= a;
                            rem    <= '0;
                            iter   <= '0;
                        end else begin
                            state <= EXEC;
                        end
                    end else if (opt_ev && opt_ok && cnt == '0) begin
                        op <= bus.opt;
                    end else if (dig_ev && cnt_room) begin
                        b         <= b_next;
                        cnt       <= cnt + CNT_W'(1);
                        display_r <= b_next;
                    end
                end

                EXEC: begin
                    done_r     <= 1'b1;
                    negative_r <= 1'b0;
                    state      <= RESULT;
                    case (op)
                        OP_ADD: begin
                            if (sum_w[WIDTH]) begin
                                state     <= ERROR;
                                error_r   <= 1'b1;
                                display_r <= '0;
                            end else begin
                                display_r <= sum_w[WIDTH-1:0];
                            end
                        end
                        OP_SUB: begin
                            negative_r <= (a < b);
                            display_r  <= (a < b) ? (b - a) : (a - b);
                        end
                        OP_MUL: begin
                            if (prod_w[2*WIDTH-1:WIDTH] != '0) begin
                                state     <= ERROR;
                                error_r   <= 1'b1;
                                display_r <= '0;
                            end else begin
                                display_r <= prod_w[WIDTH-1:0];
                            end
                        end
                        default: begin
                            state     <= ERROR;
                            error_r   <= 1'b1;
                            display_r <= '0;
                        end
                    endcase
                end

                // Busy covers exactly the WIDTH shift/subtract cycles; the final
                // cycle with busy low only transfers the result to the display.
                DIVIDE: begin
                    if (iter == '0 && b == '0) begin
                        state      <= ERROR;
                        busy_r     <= 1'b0;
                        error_r    <= 1'b1;
                        done_r     <= 1'b1;
                        negative_r <= 1'b0;
                        display_r  <= '0;
                    end else if (iter == ITER_W'(WIDTH)) begin
                        state      <= RESULT;
                        done_r     <= 1'b1;
                        negative_r <= 1'b0;
                        display_r  <= (op == OP_DIV) ? quo : rem;
                    end else begin
                        {rem, quo} <= div_step(rem, quo, b);
                        iter       <= iter + ITER_W'(1);
                        if (iter == ITER_W'(WIDTH - 1))
                            busy_r <= 1'b0;
                    end
                end

                RESULT: begin
                    if (opt_ev && opt_ok && !negative_r) begin
                        a     <= display_r;
                        b     <= '0;
                        cnt   <= '0;
                        op    <= bus.opt;
                        state <= ENTER_B;
                    end else if (dig_ev) begin
                        a          <= digit_w;
                        b          <= '0;
                        cnt        <= CNT_W'(1);
                        op         <= '0;
                        negative_r <= 1'b0;
                        display_r  <= digit_w;
                        state      <= ENTER_A;
                    end
                end

                ERROR: begin
                    if (dig_ev) begin
                        a          <= digit_w;
                        b          <= '0;
                        cnt        <= CNT_W'(1);
                        op         <= '0;
                        negative_r <= 1'b0;
                        error_r    <= 1'b0;
                        display_r  <= digit_w;
                        state      <= ENTER_A;
                    end
                end

                default: state <= ENTER_A;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_operand_engine.sv
// Bench for calc_operand_engine: directed key sequences plus random key traffic,
// compared every cycle against an arithmetic model of the calculator.
module tb_calc_operand_engine;
    localparam int W    = 16;
    localparam int MAXD = 4;
    localparam longint MAXV = (64'd1 << W) - 1;

    localparam int M_A = 0, M_B = 1, M_W = 2, M_R = 3, M_E = 4;

    logic clk;
    logic reset;

    calc_operand_engine_if #(.WIDTH(W)) bus ();

    calc_operand_engine #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int busy_cnt;
    int done_cnt;

    // model state
    bit     model_ok;
    int     mode;
    longint ma, mb;
    int     mop, mcnt, wait_left;
    longint edisp;
    bit     eneg, ebusy, edone, eerr;
    bit     pn, po, ps;
    longint pend_val;
    bit     pend_neg, pend_err;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic launch();
        pend_err = 0;
        pend_neg = 0;
        pend_val = 0;
        wait_left = 1;
        ebusy = 0;
        case (mop)
            1: begin
                pend_val = ma + mb;
                pend_err = (pend_val > MAXV);
            end
            2: begin
                pend_neg = (ma < mb);
                pend_val = pend_neg ? (mb - ma) : (ma - mb);
            end
            3: begin
                pend_val = ma * mb;
                pend_err = (pend_val > MAXV);
            end
            default: begin
                ebusy = 1;
                if (mb == 0) begin
                    pend_err = 1;
                end else begin
                    pend_val  = (mop == 4) ? (ma / mb) : (ma % mb);
                    wait_left = W + 1;
                end
            end
        endcase
        mode = M_W;
    endtask

    task automatic model_step(input bit rst, input bit np, input int n,
                              input bit opp, input int o, input bit sp);
        bit es, eo, en, ovalid;
        if (rst) begin
            mode = M_A; ma = 0; mb = 0; mop = 0; mcnt = 0; wait_left = 0;
            edisp = 0; eneg = 0; ebusy = 0; edone = 0; eerr = 0;
            pn = 0; po = 0; ps = 0;
            model_ok = 1;
            return;
        end
        es = sp && !ps && !ebusy;
        eo = opp && !po && !ebusy && !es;
        en = np && !pn && !ebusy && !es && !eo && (n <= 9);
        ovalid = (o >= 1) && (o <= 5);
        pn = np; po = opp; ps = sp;
        edone = 0;
        case (mode)
            M_A: begin
                if (es) edone = 1;
                else if (eo && ovalid) begin mop = o; mb = 0; mcnt = 0; mode = M_B; end
                else if (en && mcnt < MAXD) begin ma = ma * 10 + n; mcnt++; edisp = ma; end
            end
            M_B: begin
                if (es) launch();
                else if (eo && ovalid && mcnt == 0) mop = o;
                else if (en && mcnt < MAXD) begin mb = mb * 10 + n; mcnt++; edisp = mb; end
            end
            M_W: begin
                wait_left--;
                ebusy = (wait_left > 1);
                if (wait_left == 0) begin
                    edone = 1;
                    if (pend_err) begin
                        mode = M_E; edisp = 0; eerr = 1; eneg = 0;
                    end else begin
                        mode = M_R; edisp = pend_val; eneg = pend_neg;
                    end
                end
            end
            M_R: begin
                if (eo && ovalid && !eneg) begin
                    ma = edisp; mb = 0; mcnt = 0; mop = o; mode = M_B;
                end else if (en) begin
                    ma = n; mb = 0; mcnt = 1; eneg = 0; edisp = n; mode = M_A;
                end
            end
            default: begin
                if (en) begin
                    ma = n; mb = 0; mcnt = 1; eneg = 0; eerr = 0; edisp = n; mode = M_A;
                end
            end
        endcase
    endtask

    // per-cycle compare against the model
    initial begin
        bit s_rst, s_np, s_opp, s_sp;
        int s_n, s_o;
        forever begin
            @(posedge clk);
            s_rst = reset; s_np = bus.numPressed; s_n = int'(bus.num);
            s_opp = bus.optPressed; s_o = int'(bus.opt); s_sp = bus.submit;
            #1;
            model_step(s_rst, s_np, s_n, s_opp, s_o, s_sp);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (model_ok) begin
                vectors++;
                if (longint'(bus.display) != edisp || bus.negative != eneg ||
                    bus.busy != ebusy || bus.done != edone || bus.error != eerr) begin
                    miscompares++;
                    $display("FAIL cycle@%0t: disp=%0d/%0d neg=%0b/%0b busy=%0b/%0b done=%0b/%0b err=%0b/%0b (got/expected)",
                             $time, bus.display, edisp, bus.negative, eneg, bus.busy, ebusy,
                             bus.done, edone, bus.error, eerr);
                end
            end
        end
    end

    task automatic key(input bit np, input int n, input bit opp, input int o,
                       input bit sp, input int hold, input int gap);
        bus.num = 4'(n); bus.numPressed = np;
        bus.opt = 3'(o); bus.optPressed = opp;
        bus.submit = sp;
        repeat (hold) @(negedge clk);
        bus.numPressed = 0; bus.optPressed = 0; bus.submit = 0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic dig(input int d);   key(1, d, 0, 0, 0, 5, 2); endtask
    task automatic oper(input int o);  key(0, 0, 1, o, 0, 5, 2); endtask
    task automatic press_submit();     key(0, 0, 0, 0, 1, 5, 2); endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
    endtask

    initial begin
        clk = 0; reset = 1;
        vectors = 0; miscompares = 0; busy_cnt = 0; done_cnt = 0; model_ok = 0;
        bus.num = 0; bus.numPressed = 0; bus.opt = 0; bus.optPressed = 0; bus.submit = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("reset_display", bus.display, 0);
        check("reset_flags", {bus.negative, bus.busy, bus.done, bus.error}, 0);

        // 12 + 34
        dig(1); dig(2); oper(1); dig(3); dig(4);
        done_cnt = 0;
        press_submit();
        repeat (3) @(negedge clk);
        check("add_46", bus.display, 46);
        check("add_neg", bus.negative, 0);
        check("add_done_once", done_cnt, 1);

        // 5 - 12, then + is ignored while negative
        do_reset();
        dig(5); oper(2); dig(1); dig(2); press_submit();
        repeat (3) @(negedge clk);
        check("sub_7", bus.display, 7);
        check("sub_neg", bus.negative, 1);
        oper(1); dig(0);
        check("neg_opt_ignored", bus.display, 0);
        check("neg_cleared", bus.negative, 0);

        // 300 * 300 overflows, digit recovers
        do_reset();
        dig(3); dig(0); dig(0); oper(3); dig(3); dig(0); dig(0); press_submit();
        repeat (3) @(negedge clk);
        check("mul_err", bus.error, 1);
        check("mul_err_disp", bus.display, 0);
        dig(9);
        check("err_recover_disp", bus.display, 9);
        check("err_recover_flag", bus.error, 0);

        // 100 / 7 and 100 % 7
        do_reset();
        dig(1); dig(0); dig(0); oper(4); dig(7);
        busy_cnt = 0;
        press_submit();
        repeat (20) @(negedge clk);
        check("div_busy_cycles", busy_cnt, 16);
        check("div_14", bus.display, 14);
        do_reset();
        dig(1); dig(0); dig(0); oper(5); dig(7); press_submit();
        repeat (20) @(negedge clk);
        check("mod_2", bus.display, 2);
        do_reset();
        dig(7); oper(4); dig(0); press_submit();
        repeat (3) @(negedge clk);
        check("div0_err", bus.error, 1);

        // digit limit, long hold, submit beats operator
        do_reset();
        dig(1); dig(2); dig(3); dig(4); dig(5);
        check("max_digits", bus.display, 1234);
        do_reset();
        key(1, 7, 0, 0, 0, 20, 2);
        check("hold_once", bus.display, 7);
        done_cnt = 0;
        key(0, 0, 1, 1, 1, 5, 2);
        check("simul_done", done_cnt, 1);
        dig(2);
        check("simul_submit_wins", bus.display, 72);

        // reset in the middle of a divide
        do_reset();
        dig(8); oper(4); dig(3);
        bus.submit = 1;
        repeat (8) @(negedge clk);
        check("mid_div_busy", bus.busy, 1);
        reset = 1; bus.submit = 0;
        @(negedge clk);
        reset = 0;
        check("mid_reset_busy", bus.busy, 0);
        check("mid_reset_disp", bus.display, 0);
        check("mid_reset_done", bus.done, 0);
        dig(4);
        check("mid_reset_digit", bus.display, 4);

        // random key traffic
        for (int i = 0; i < 500; i++) begin
            int kind, hold, gap, d, o;
            kind = $urandom_range(0, 40);
            hold = $urandom_range(1, 4);
            gap  = $urandom_range(0, 3);
            d    = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            o    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 5);
            if (kind < 20)       key(1, d, 0, 0, 0, hold, gap);
            else if (kind < 28)  key(0, 0, 1, o, 0, hold, gap);
            else if (kind < 34)  key(0, 0, 0, 0, 1, hold, gap);
            else if (kind < 38)  key($urandom_range(0, 1) == 1, d, $urandom_range(0, 1) == 1, o,
                                     $urandom_range(0, 1) == 1, hold, gap);
            else if (kind < 40)  repeat (18) @(negedge clk);
            else begin
                reset = 1;
                @(negedge clk);
                reset = 0;
            end
        end
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
